fir_decim: RTL and testbench

Decimation stage directly downstream of the `fir` filter. It consumes the filter's signed NB_DATA-bit output stream and reduces the rate by DEC_FACTOR using integrate-and-dump: it sums DEC_FACTOR accepted samples and emits one result. Results pass through a 2-entry output FIFO with a valid/ready handshake, so a stalled consumer never corrupts the running group. An overflow flag reports results dropped while the FIFO is full.

---
 rtl/fir_decim.sv | 179 +++++++++++++++++
 tb/tb_fir_decim.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim.sv
// Decimator after the fir filter: integrate-and-dump (FIR_DECIM_INTEG_EN) or pure downsample by DEC_FACTOR.
// Latency: result visible one cycle after the last sample of a group is presented.
// Backpressure: 2-entry output FIFO on o_valid/i_ready; a result arriving at a full, non-popping FIFO is dropped and latched in o_overflow.

module fifo #(
    parameter int WIDTH = 8
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_drop,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    input  logic             pop_rdy
);
    // ent0 is always the head; after the last pop it keeps the popped value.
    logic [1:0]       cnt;
    logic [WIDTH-1:0] ent0;
    logic [WIDTH-1:0] ent1;
    logic             pop;

    assign pop       = (cnt != 2'd0) && pop_rdy;
    assign pop_vld   = (cnt != 2'd0);
    assign pop_dat   = ent0;
    assign push_drop = push_vld && (cnt == 2'd2) && !pop;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (push_vld) begin
                        ent0 <= push_dat;
                        cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push_vld) begin
                        if (pop) begin
                            ent0 <= push_dat;
                        end else begin
                            ent1 <= push_dat;
                            cnt  <= 2'd2;
                        end
                    end else if (pop) begin
                        cnt <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        ent0 <= ent1;
                        if (push_vld) begin
                            ent1 <= push_dat;
                        end else begin
                            cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

module fir_decim #(
    parameter  int NB_DATA    = 8,
    parameter  int DEC_FACTOR = 4,
    parameter  int NB_OUT     = 10,
    localparam int NB_PH      = $clog2(DEC_FACTOR)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    input  logic               i_ready,
    output logic [NB_OUT-1:0]  o_data,
    output logic               o_valid,
    output logic [NB_PH-1:0]   o_phase,
    output logic               o_overflow
);
    localparam logic [NB_PH-1:0] PH_LAST = NB_PH'(DEC_FACTOR - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              leave;
    logic              dump;
    logic [NB_PH-1:0]  phase_q;
    logic [NB_OUT-1:0] samp_ext;
    logic [NB_OUT-1:0] dump_dat;
    logic              push_drop;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        leave   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_enable) state_d = RUN;
            end
            RUN: begin
                accept = i_valid;
                if (!i_enable) begin
                    state_d = IDLE;
                    leave   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dump     = accept && (phase_q == PH_LAST);
    assign samp_ext = {{(NB_OUT - NB_DATA){i_data[NB_DATA-1]}}, i_data};

    // Dropping enable discards the partial group along with its phase.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            phase_q <= '0;
        end else if (leave) begin
            phase_q <= '0;
        end else if (accept) begin
            phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + NB_PH'(1);
        end
    end

`ifdef FIR_DECIM_INTEG_EN
    logic [NB_OUT-1:0] acc_q;

    // NB_OUT is sized for the full group, so two's-complement wrap cannot occur.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            acc_q <= '0;
        end else if (leave || dump) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= acc_q + samp_ext;
        end
    end

    assign dump_dat = acc_q + samp_ext;
`else
    assign dump_dat = samp_ext;
`endif

    fifo #(.WIDTH(NB_OUT)) u_out_fifo (
        .core_clk  (i_clk),
        .arst_n    (i_rst),
        .push_vld  (dump),
        .push_dat  (dump_dat),
        .push_drop (push_drop),
        .pop_vld   (o_valid),
        .pop_dat   (o_data),
        .pop_rdy   (i_ready)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_overflow <= 1'b0;
        end else if (push_drop) begin
            o_overflow <= 1'b1;
        end
    end

    assign o_phase = phase_q;
endmodule

// File: tb/tb_fir_decim.sv
// Bench for fir_decim: directed test-plan steps plus a randomized run against a queue-based reference.
module tb_fir_decim;
    localparam int NB_DATA    = 8;
    localparam int DEC_FACTOR = 4;
    localparam int NB_OUT     = 10;
    localparam int NB_PH      = $clog2(DEC_FACTOR);
    localparam int MASK       = (1 << NB_OUT) - 1;
`ifdef FIR_DECIM_INTEG_EN
    localparam bit INTEG = 1'b1;
`else
    localparam bit INTEG = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               vld = 1'b0;
    logic               rdy = 1'b0;
    logic [NB_DATA-1:0] dat = '0;
    logic [NB_OUT-1:0]  o_data;
    logic               o_valid;
    logic [NB_PH-1:0]   o_phase;
    logic               o_overflow;

    always #5 clk = ~clk;

    fir_decim #(.NB_DATA(NB_DATA), .DEC_FACTOR(DEC_FACTOR), .NB_OUT(NB_OUT)) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_enable   (en),
        .i_data     (dat),
        .i_valid    (vld),
        .i_ready    (rdy),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_phase    (o_phase),
        .o_overflow (o_overflow)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference: current group as a list of samples, output FIFO as a queue.
    int grp[$];
    int fq[$];
    int m_last;
    bit m_run;
    bit m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        grp.delete();
        fq.delete();
        m_last = 0;
        m_run  = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge();
        bit pop;
        bit dump;
        int res;
        pop  = (fq.size() != 0) && rdy;
        dump = 1'b0;
        res  = 0;
        if (m_run && vld) begin
            grp.push_back(int'($signed(dat)));
            if (grp.size() == DEC_FACTOR) begin
                dump = 1'b1;
                if (INTEG) foreach (grp[i]) res += grp[i];
                else res = grp[DEC_FACTOR-1];
                grp.delete();
            end
        end
        if (m_run && !en) grp.delete();
        m_run = en;
        if (pop) m_last = fq.pop_front();
        if (dump) begin
            if (fq.size() < 2) fq.push_back(res);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_all();
        int e;
        e = (fq.size() != 0) ? fq[0] : m_last;
        chk("o_valid", 32'(o_valid), 32'(fq.size() != 0));
        chk("o_phase", 32'(o_phase), grp.size());
        chk("o_overflow", 32'(o_overflow), 32'(m_ovf));
        chk("o_data", 32'(o_data), e & MASK);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int pulses;
        model_reset();

        // Reset held: everything zero.
        repeat (3) begin
            @(negedge clk);
            chk("rst_o_data", 32'(o_data), 0);
            chk("rst_o_valid", 32'(o_valid), 0);
            chk("rst_o_phase", 32'(o_phase), 0);
            chk("rst_o_overflow", 32'(o_overflow), 0);
        end
        rst_n = 1'b1;

        // Basic rate with constant 3.
        en = 1'b1; vld = 1'b1; rdy = 1'b1; dat = 8'd3;
        pulses = 0;
        repeat (13) begin
            step();
            if (o_valid) pulses++;
        end
        chk("rate_pulses", pulses, 3);

        // Negative extreme.
        dat = 8'h80;
        repeat (4) step();
        chk("neg_extreme", 32'(o_data), INTEG ? 32'h200 : 32'h380);
        chk("neg_no_ovf", 32'(o_overflow), 0);
        vld = 1'b0;
        step();

        // Backpressure over three groups.
        rdy = 1'b0; vld = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            dat = NB_DATA'(i);
            step();
        end
        chk("bp_head", 32'(o_data), INTEG ? 10 : 4);
        chk("bp_ovf", 32'(o_overflow), 1);
        vld = 1'b0; rdy = 1'b1;
        step();
        chk("bp_second", 32'(o_data), INTEG ? 26 : 8);
        step();
        chk("bp_empty", 32'(o_valid), 0);
        chk("bp_ovf_sticky", 32'(o_overflow), 1);

        // Input gaps.
        dat = 8'd2;
        for (int i = 0; i < 8; i++) begin
            vld = (i % 2 == 0);
            step();
        end
        chk("gap_result", 32'(o_data), INTEG ? 8 : 2);

        // Enable drop mid-group.
        vld = 1'b1; dat = 8'd5;
        repeat (2) step();
        en = 1'b0; vld = 1'b0;
        step();
        chk("drop_phase", 32'(o_phase), 0);
        en = 1'b1;
        step();
        vld = 1'b1; dat = 8'd1;
        repeat (4) step();
        chk("drop_result", 32'(o_data), INTEG ? 4 : 1);
        chk("drop_phase_end", 32'(o_phase), 0);

        // Async reset mid-group with one FIFO entry.
        rdy = 1'b0;
        repeat (6) begin
            dat = NB_DATA'($urandom);
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_o_valid", 32'(o_valid), 0);
        chk("arst_o_phase", 32'(o_phase), 0);
        chk("arst_o_data", 32'(o_data), 0);
        chk("arst_o_overflow", 32'(o_overflow), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; rdy = 1'b1; vld = 1'b1; dat = 8'd3;
        repeat (5) step();
        chk("arst_regroup", 32'(o_data), INTEG ? 12 : 3);

        // Randomized traffic.
        repeat (400) begin
            en  = ($urandom % 16) != 0;
            vld = ($urandom % 4) != 0;
            rdy = ($urandom % 3) != 0;
            dat = NB_DATA'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
